sync_cntr_seq_ctrl: RTL and testbench

Sequencer for an external loadable synchronous up-counter with a carry flag (carry = count at all-ones). Drives the counter's load, cnt_en and data_in. Runs a programmed number of periods, where one period runs from a preset value up to terminal count. Reports busy, period progress and a done pulse to the host logic.

---
 rtl/sync_cntr_seq_pkg.sv | 14 +
 rtl/sync_cntr_seq_ctrl.sv | 116 +++++++++++
 tb/tb_sync_cntr_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_cntr_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default widths.
package sync_cntr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_REP_W = 4;

endpackage

// File: rtl/sync_cntr_seq_ctrl.sv
// Sequencer for an external loadable up-counter: runs reps periods from preset to terminal count.
// Optional sticky done interrupt (irq/irq_clr) enabled by defining SYNC_CNTR_SEQ_IRQ_EN.
module sync_cntr_seq_ctrl
  import sync_cntr_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] preset,
  input  logic [REP_W-1:0] reps,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] wrap_cnt,
  output logic             cntr_load,
  output logic             cntr_en,
  input  logic             cntr_carry,
`ifdef SYNC_CNTR_SEQ_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [CNT_W-1:0] cntr_data
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] preset_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] wrap_q;
  logic [REP_W-1:0] wrap_inc;
  logic             accept;
  logic             period_end;

  assign accept     = (state == IDLE) && start;
  // A carry only ends a period when the cycle is neither aborted nor paused.
  assign period_end = (state == RUN) && !abort && !pause && cntr_carry;
  assign wrap_inc   = wrap_q + REP_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      preset_q <= '0;
      reps_q   <= '0;
      wrap_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        preset_q <= preset;
        reps_q   <= reps;
        wrap_q   <= '0;
      end else if (period_end) begin
        wrap_q <= wrap_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cntr_load = 1'b0;
    cntr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (reps == '0) ? DONE : LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cntr_load = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = RUN;
        end else if (cntr_carry) begin
          // Last period leaves the counter parked at all-ones; otherwise reload preset.
          if (wrap_inc == reps_q) state_nxt = DONE;
          else                    cntr_load = 1'b1;
        end else begin
          cntr_en = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wrap_cnt  = wrap_q;
  assign cntr_data = preset_q;

`ifdef SYNC_CNTR_SEQ_IRQ_EN
  logic irq_q;

  // Set dominates clear, so a done coinciding with irq_clr keeps the flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= (irq_q & ~irq_clr) | done;
  end

  assign irq = irq_q | done;
`endif

endmodule

// File: tb/tb_sync_cntr_seq_ctrl.sv
// Testbench for sync_cntr_seq_ctrl with a behavioural external counter and a per-cycle expectation queue.
module tb_sync_cntr_seq_ctrl;

  localparam int CNT_W = 4;
  localparam int REP_W = 4;
  localparam int OW    = 4 + REP_W + CNT_W;

  logic             clk;
  logic             rstn;
  logic             start;
  logic [CNT_W-1:0] preset;
  logic [REP_W-1:0] reps;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] wrap_cnt;
  logic             cntr_load;
  logic             cntr_en;
  logic [CNT_W-1:0] cntr_data;
  logic             cntr_carry;
`ifdef SYNC_CNTR_SEQ_IRQ_EN
  logic             irq_clr;
  logic             irq;
`endif

  logic [CNT_W-1:0] cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    int               idx;
    logic             busy;
    logic             done;
    logic             load;
    logic             en;
    logic [REP_W-1:0] wrap;
  } exp_t;

  exp_t exp_q[$];

  sync_cntr_seq_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .preset     (preset),
    .reps       (reps),
    .pause      (pause),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .wrap_cnt   (wrap_cnt),
    .cntr_load  (cntr_load),
    .cntr_en    (cntr_en),
    .cntr_carry (cntr_carry),
`ifdef SYNC_CNTR_SEQ_IRQ_EN
    .irq_clr    (irq_clr),
    .irq        (irq),
`endif
    .cntr_data  (cntr_data)
  );

  // External loadable up-counter with carry at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          cnt <= '0;
    else if (cntr_load) cnt <= cntr_data;
    else if (cntr_en)   cnt <= cnt + CNT_W'(1);
  end
  assign cntr_carry = &cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int idx, input logic b, input logic d, input logic l,
                      input logic e, input int w);
    exp_t x;
    x.idx  = idx;
    x.busy = b;
    x.done = d;
    x.load = l;
    x.en   = e;
    x.wrap = REP_W'(w);
    exp_q.push_back(x);
  endtask

  // Expected timeline: idx 1 is the cycle after the accepting edge; RUN starts at idx 2.
  // Each period is 2^CNT_W - p unpaused RUN cycles, the last of which is the carry cycle.
  task automatic gen(input int p, input int r, input int pf, input int pl, input int ab);
    int idx, prog, wr, len;
    bit paused;
    len = (1 << CNT_W) - p;
    if (r == 0) begin
      push(1, 0, 1, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0);
      return;
    end
    if (ab == 1) begin
      push(1, 1, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0);
      return;
    end
    push(1, 1, 0, 1, 0, 0);
    idx  = 2;
    prog = 0;
    wr   = 0;
    while (idx < 400) begin
      paused = (idx - 2 >= pf) && (idx - 2 < pf + pl);
      if (idx == ab) begin
        push(idx, 1, 0, 0, 0, wr);
        push(idx + 1, 0, 0, 0, 0, wr);
        return;
      end
      if (paused) begin
        push(idx, 1, 0, 0, 0, wr);
      end else if (prog == len - 1) begin
        push(idx, 1, 0, (wr + 1 < r), 0, wr);
        wr++;
        prog = 0;
        if (wr == r) begin
          push(idx + 1, 0, 1, 0, 0, wr);
          push(idx + 2, 0, 0, 0, 0, wr);
          return;
        end
      end else begin
        push(idx, 1, 0, 0, 1, wr);
        prog++;
      end
      idx++;
    end
  endtask

  // Starts a run, then checks every cycle against the queued timeline while
  // scrambling preset/reps and holding start high whenever it must be ignored.
  task automatic run_check(input string name, input int p, input int r,
                           input int pf, input int pl, input int ab);
    exp_t e;
    logic [OW-1:0] got, want;
    int idx;
    gen(p, r, pf, pl, ab);
    preset = CNT_W'(p);
    reps   = REP_W'(r);
    start  = 1'b1;
    pause  = 1'b0;
    abort  = 1'b0;
    @(posedge clk);
    #1;
    idx = 1;
    while (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      pause  = (idx >= 2) && (idx - 2 >= pf) && (idx - 2 < pf + pl);
      abort  = (idx == ab);
      start  = (exp_q.size() > 0);
      preset = CNT_W'($urandom);
      reps   = REP_W'($urandom);
      @(negedge clk);
      got  = {busy, done, cntr_load, cntr_en, wrap_cnt, cntr_data};
      want = {e.busy, e.done, e.load, e.en, e.wrap, CNT_W'(p)};
      chk_cnt++;
      if (got !== want)
        $display("FAIL %s cycle k+%0d: {busy,done,load,en,wrap,data} got %b expected %b",
                 name, e.idx, got, want);
      else
        pass_cnt++;
      @(posedge clk);
      #1;
      idx++;
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_cnt_parked(input string name);
    chk_cnt++;
    if (cnt !== {CNT_W{1'b1}})
      $display("FAIL %s counter_parked: got %0d expected %0d", name, cnt, {CNT_W{1'b1}});
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    rstn = 1'b0;
    #1;
    got = {busy, done, cntr_load, cntr_en, wrap_cnt, cntr_data};
    chk_cnt++;
    if (got !== '0) $display("FAIL reset_outputs: got %b expected %b", got, {OW{1'b0}});
    else            pass_cnt++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    got = {busy, done, cntr_load, cntr_en, wrap_cnt, cntr_data};
    chk_cnt++;
    if (got !== '0) $display("FAIL idle_after_reset: got %b expected %b", got, {OW{1'b0}});
    else            pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_periods();
    run_check("preset12_reps2", 12, 2, 0, 0, 0);
    check_cnt_parked("preset12_reps2");
  endtask

  task automatic test_one_cycle_periods();
    run_check("preset15_reps3", 15, 3, 0, 0, 0);
    check_cnt_parked("preset15_reps3");
  endtask

  task automatic test_zero_reps();
    run_check("reps0", 7, 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    // Pause covers the first carry cycle and the two cycles after it.
    run_check("pause_over_carry", 12, 1, 3, 3, 0);
    check_cnt_parked("pause_over_carry");
    run_check("pause_mid_period", 10, 2, 1, 2, 0);
  endtask

  task automatic test_abort();
    run_check("abort_run2", 12, 2, 0, 0, 3);
    run_check("restart_after_abort", 12, 2, 0, 0, 0);
    run_check("abort_in_load", 9, 1, 0, 0, 1);
    run_check("abort_second_period", 12, 2, 0, 0, 7);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_a", 14, 2, 0, 0, 0);
    run_check("b2b_b", 13, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    logic [OW-1:0] got;
    preset = CNT_W'(12);
    reps   = REP_W'(2);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_before_reset: got %b expected 1", busy);
    else               pass_cnt++;
    #2;
    rstn = 1'b0;
    #1;
    got = {busy, done, cntr_load, cntr_en, wrap_cnt, cntr_data};
    chk_cnt++;
    if (got !== '0) $display("FAIL reset_mid_run: got %b expected %b", got, {OW{1'b0}});
    else            pass_cnt++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if ({busy, done} !== 2'b00) $display("FAIL no_done_after_reset: got %b expected 00", {busy, done});
      else                        pass_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SYNC_CNTR_SEQ_IRQ_EN
  task automatic test_irq();
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    reps    = '0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({done, irq} !== 2'b11) $display("FAIL irq_with_done: got %b expected 11", {done, irq});
    else                       pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_sticky: got %b expected 1", irq);
    else              pass_cnt++;
    @(posedge clk);
    #1;
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", irq);
    else              pass_cnt++;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_set_beats_clear: got %b expected 1", irq);
    else              pass_cnt++;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    start  = 1'b0;
    preset = '0;
    reps   = '0;
    pause  = 1'b0;
    abort  = 1'b0;
    rstn   = 1'b0;
`ifdef SYNC_CNTR_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    test_reset();
    test_two_periods();
    test_one_cycle_periods();
    test_zero_reps();
    test_pause();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SYNC_CNTR_SEQ_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
